// File: rtl/fi_pkg.sv
// Shared encodings for the fault injector: request modes, FSM states and LFSR constants.
package fi_pkg;

    typedef enum logic [1:0] {
        MODE_NONE   = 2'd0,
        MODE_SINGLE = 2'd1,
        MODE_BURST  = 2'd2,
        MODE_RANDOM = 2'd3
    } fi_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_INJECT = 2'd2
    } fi_state_e;

    // x^16+x^14+x^13+x^11+1 as a right-shifting Fibonacci register: feedback from bits 0,2,3,5.
    localparam logic [15:0] FI_LFSR_TAPS = 16'h002D;
    localparam logic [15:0] FI_SEED      = 16'hACE1;

    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return {^(q & FI_LFSR_TAPS), q[15:1]};
    endfunction

endpackage

// File: rtl/fi_lfsr.sv
// 16-bit Fibonacci LFSR that advances one step on each enabled clock.
module fi_lfsr
    import fi_pkg::*;
#(
    parameter logic [15:0] SEED = FI_SEED
) (
    input  logic        clk,
    input  logic        rst_in,
    input  logic        en,
    output logic [15:0] q
);

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in)
            q <= SEED;
        else if (en)
            q <= lfsr_next(q);
    end

endmodule

// File: rtl/fault_injector.sv
// Single-bit fault injector for NCH redundant lanes; FAULT_INJECT_EN enables the injector,
// otherwise the block is a pure wire-through with no state.
module fault_injector
    import fi_pkg::*;
#(
    parameter int          WIDTH = 32,
    parameter int          NCH   = 3,
    parameter int          DLY_W = 16,
    parameter logic [15:0] SEED  = FI_SEED,
    localparam int         CH_W  = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int         BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic                   clk,
    input  logic                   rst_in,
    input  logic [NCH*WIDTH-1:0]   data_in,
    output logic [NCH*WIDTH-1:0]   data_out,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [1:0]             cfg_mode,
    input  logic [CH_W-1:0]        cfg_chan,
    input  logic [BIT_W-1:0]       cfg_bit,
    input  logic [DLY_W-1:0]       cfg_delay,
    input  logic [DLY_W-1:0]       cfg_len,
    input  logic                   abort,
    output logic                   cfg_err,
    output logic                   inj_active,
    output logic [15:0]            inj_count
);

    localparam int N = NCH * WIDTH;

`ifdef FAULT_INJECT_EN

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    fi_state_e        state_q, state_d;
    fi_mode_e         mode_q, mode_d;
    logic [CH_W-1:0]  chan_q, chan_d;
    logic [BIT_W-1:0] bit_q, bit_d, rnd_bit, bit_sel;
    logic [DLY_W-1:0] len_q, len_d, cnt_q, cnt_d;
    logic [N-1:0]     mask_q, mask_d;
    logic [15:0]      inj_count_q, lfsr_q;
    logic [31:0]      flip_idx;
    logic             err_q, err_d, req_bad, load_inj, inj_next, lfsr_en;
    logic             unused_lfsr;

    fi_lfsr #(.SEED(SEED)) u_lfsr (
        .clk    (clk),
        .rst_in (rst_in),
        .en     (lfsr_en),
        .q      (lfsr_q)
    );

    // Only the low bits of the LFSR pick the bit position.
    assign unused_lfsr = ^lfsr_q;

    always_comb begin
        rnd_bit = lfsr_q[BIT_W-1:0];
        if (32'(lfsr_q[BIT_W-1:0]) >= WIDTH)
            rnd_bit = lfsr_q[BIT_W-1:0] - BIT_W'(WIDTH);
    end

    assign req_bad = (cfg_mode == MODE_NONE) || (32'(cfg_chan) >= NCH) ||
                     (((cfg_mode == MODE_SINGLE) || (cfg_mode == MODE_BURST)) &&
                      (32'(cfg_bit) >= WIDTH));

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        chan_d   = chan_q;
        bit_d    = bit_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        err_d    = 1'b0;
        load_inj = 1'b0;
        inj_next = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_valid && !abort) begin
                    if (req_bad) begin
                        err_d = 1'b1;
                    end else begin
                        mode_d = fi_mode_e'(cfg_mode);
                        chan_d = cfg_chan;
                        bit_d  = cfg_bit;
                        len_d  = cfg_len;
                        if (cfg_delay != '0) begin
                            state_d = ST_WAIT;
                            cnt_d   = cfg_delay;
                        end else begin
                            load_inj = 1'b1;
                        end
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == DLY_W'(1))
                    load_inj = 1'b1;
                else
                    cnt_d = cnt_q - DLY_W'(1);
            end
            ST_INJECT: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d    = cnt_q - DLY_W'(1);
                    inj_next = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // cnt holds the INJECT cycles still to come after the current one.
        if (load_inj) begin
            state_d  = ST_INJECT;
            inj_next = 1'b1;
            cnt_d    = ((mode_d == MODE_SINGLE) || (len_d == '0)) ? '0 : len_d - DLY_W'(1);
        end
        if (abort) begin
            state_d  = ST_IDLE;
            inj_next = 1'b0;
        end
    end

    // Mask for the coming cycle; random mode consumes the current LFSR value and steps it.
    always_comb begin
        bit_sel  = (mode_d == MODE_RANDOM) ? rnd_bit : bit_d;
        flip_idx = 32'(chan_d) * WIDTH + 32'(bit_sel);
        mask_d   = '0;
        lfsr_en  = 1'b0;
        if (inj_next) begin
            mask_d  = ONE << flip_idx;
            lfsr_en = (mode_d == MODE_RANDOM);
        end
    end

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_NONE;
            chan_q      <= '0;
            bit_q       <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            mask_q      <= '0;
            err_q       <= 1'b0;
            inj_count_q <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            chan_q  <= chan_d;
            bit_q   <= bit_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            err_q   <= err_d;
            if ((state_q == ST_INJECT) && (inj_count_q != 16'hFFFF))
                inj_count_q <= inj_count_q + 16'd1;
        end
    end

    assign data_out   = data_in ^ mask_q;
    assign cfg_ready  = (state_q == ST_IDLE);
    assign cfg_err    = err_q;
    assign inj_active = |mask_q;
    assign inj_count  = inj_count_q;

`else

    logic unused_cfg;

    assign unused_cfg = ^{clk, rst_in, cfg_valid, cfg_mode, cfg_chan, cfg_bit,
                          cfg_delay, cfg_len, abort};

    assign data_out   = data_in;
    assign cfg_ready  = 1'b0;
    assign cfg_err    = 1'b0;
    assign inj_active = 1'b0;
    assign inj_count  = 16'd0;

`endif

endmodule

// File: tb/tb_fault_injector.sv
// Directed bench for fault_injector with a per-cycle expected-mask scoreboard.
module tb_fault_injector;

    localparam int WIDTH = 32;
    localparam int NCH   = 3;
    localparam int DLY_W = 16;
    localparam int N     = NCH * WIDTH;
`ifdef FAULT_INJECT_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_in;
    logic [N-1:0]     data_in, data_out;
    logic             cfg_valid, cfg_ready, abort, cfg_err, inj_active;
    logic [1:0]       cfg_mode, cfg_chan;
    logic [4:0]       cfg_bit;
    logic [DLY_W-1:0] cfg_delay, cfg_len;
    logic [15:0]      inj_count;

    int           checks = 0;
    int           errors = 0;
    logic [N-1:0] exp_q[$];
    logic [15:0]  mdl_lfsr;

    always #5 clk = ~clk;

    fault_injector #(.WIDTH(WIDTH), .NCH(NCH), .DLY_W(DLY_W), .SEED(16'hACE1)) dut (
        .clk        (clk),
        .rst_in     (rst_in),
        .data_in    (data_in),
        .data_out   (data_out),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_mode   (cfg_mode),
        .cfg_chan   (cfg_chan),
        .cfg_bit    (cfg_bit),
        .cfg_delay  (cfg_delay),
        .cfg_len    (cfg_len),
        .abort      (abort),
        .cfg_err    (cfg_err),
        .inj_active (inj_active),
        .inj_count  (inj_count)
    );

    task automatic check_v(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected one-hot flip; zero when the injector is compiled out.
    function automatic logic [N-1:0] bitmask(input int idx);
        logic [N-1:0] m;
        m = {{(N-1){1'b0}}, 1'b1} << idx;
        return EN ? m : '0;
    endfunction

    function automatic logic [15:0] ref_step(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    function automatic int ref_idx(input logic [15:0] s);
        int i;
        i = int'(s[4:0]);
        if (i >= WIDTH) i = i - WIDTH;
        return i;
    endfunction

    task automatic push_n(input logic [N-1:0] m, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(m);
    endtask

    task automatic req(input int m, input int c, input int b, input int d, input int l);
        cfg_valid = 1'b1;
        cfg_mode  = 2'(m);
        cfg_chan  = 2'(c);
        cfg_bit   = 5'(b);
        cfg_delay = 16'(d);
        cfg_len   = 16'(l);
    endtask

    // Finish the current cycle: compare data_out against the scoreboard, then step to the next.
    task automatic tick();
        logic [N-1:0] m;
        @(negedge clk);
        m = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check_v("data_out", data_out, data_in ^ m);
        @(posedge clk);
        #1;
        data_in   = {$urandom, $urandom, $urandom};
        cfg_valid = 1'b0;
        abort     = 1'b0;
    endtask

    initial begin
        rst_in    = 1'b1;
        cfg_valid = 1'b0;
        abort     = 1'b0;
        cfg_mode  = '0;
        cfg_chan  = '0;
        cfg_bit   = '0;
        cfg_delay = '0;
        cfg_len   = '0;
        data_in   = {$urandom, $urandom, $urandom};
        mdl_lfsr  = 16'hACE1;
        #1 rst_in = 1'b0;
        #2;
        check_v("rst_data_out", data_out, data_in);
        check_1("rst_ready", cfg_ready, EN);
        check_1("rst_err", cfg_err, 1'b0);
        check_1("rst_active", inj_active, 1'b0);
        check_16("rst_count", inj_count, 16'd0);
        @(posedge clk);
        #1;
        rst_in = 1'b1;
        tick();
        tick();

        // single: bit 37 flips in cycle 4 only; busy requests and cfg changes ignored
        req(1, 1, 5, 3, 7);
        push_n('0, 4);
        push_n(bitmask(37), 1);
        tick();
        cfg_mode = 2'd2; cfg_chan = 2'd0; cfg_bit = 5'd9; cfg_len = 16'd5;
        check_1("single_busy_ready", cfg_ready, 1'b0);
        tick();
        req(1, 0, 0, 0, 0);
        tick();
        tick();
        check_1("single_active", inj_active, EN);
        tick();
        check_1("single_done_active", inj_active, 1'b0);
        check_1("single_done_ready", cfg_ready, EN);
        check_16("single_count", inj_count, EN ? 16'd1 : 16'd0);

        // burst: bit 95 for 4 cycles right after accept
        req(2, 2, 31, 0, 4);
        push_n('0, 1);
        push_n(bitmask(95), 4);
        check_1("burst_idle_ready", cfg_ready, EN);
        tick();
        for (int i = 0; i < 4; i++) begin
            check_1("burst_ready", cfg_ready, 1'b0);
            check_1("burst_active", inj_active, EN);
            tick();
        end
        check_1("burst_done_ready", cfg_ready, EN);
        check_16("burst_count", inj_count, EN ? 16'd5 : 16'd0);

        // reject: bad channel, then mode 0
        req(1, 3, 0, 0, 0);
        tick();
        check_1("rej_chan_err", cfg_err, EN);
        check_1("rej_chan_ready", cfg_ready, EN);
        check_1("rej_chan_active", inj_active, 1'b0);
        check_16("rej_chan_count", inj_count, EN ? 16'd5 : 16'd0);
        tick();
        check_1("rej_err_pulse", cfg_err, 1'b0);
        req(0, 0, 0, 0, 0);
        tick();
        check_1("rej_mode_err", cfg_err, EN);
        tick();

        // abort during the third INJECT cycle
        req(2, 0, 7, 0, 10);
        push_n('0, 1);
        push_n(bitmask(7), 3);
        push_n('0, 1);
        tick();
        tick();
        tick();
        abort = 1'b1;
        tick();
        check_1("abort_active", inj_active, 1'b0);
        check_1("abort_ready", cfg_ready, EN);
        check_16("abort_count", inj_count, EN ? 16'd8 : 16'd0);
        tick();
        tick();

        // random: 8 LFSR-chosen bits of channel 1 after a 2-cycle wait
        req(3, 1, 0, 2, 8);
        push_n('0, 3);
        for (int k = 0; k < 8; k++) begin
            push_n(bitmask(WIDTH + ref_idx(mdl_lfsr)), 1);
            mdl_lfsr = ref_step(mdl_lfsr);
        end
        for (int k = 0; k < 11; k++) begin
            tick();
            if (k >= 2 && k < 10) check_1("rand_active", inj_active, EN);
        end
        check_1("rand_done_ready", cfg_ready, EN);
        check_16("rand_count", inj_count, EN ? 16'd16 : 16'd0);

        // reset mid-burst clears the mask without a clock edge
        req(2, 2, 0, 0, 6);
        push_n('0, 1);
        push_n(bitmask(64), 6);
        tick();
        tick();
        #1 rst_in = 1'b0;
        #1;
        check_v("rst_async_data", data_out, data_in);
        check_1("rst_async_active", inj_active, 1'b0);
        exp_q.delete();
        mdl_lfsr = 16'hACE1;
        tick();
        tick();
        rst_in = 1'b1;
        check_16("rst_rel_count", inj_count, 16'd0);
        check_1("rst_rel_ready", cfg_ready, EN);
        tick();

        // random with len 0 after reset: one cycle, LFSR back at its seed
        req(3, 0, 0, 0, 0);
        push_n('0, 1);
        push_n(bitmask(ref_idx(mdl_lfsr)), 1);
        tick();
        check_1("rand1_active", inj_active, EN);
        tick();
        check_1("rand1_done", inj_active, 1'b0);
        check_16("rand1_count", inj_count, EN ? 16'd1 : 16'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fault_injector.md
FAULT_INJECTOR -- requirements
Module: fault_injector

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the bits per channel.
REQ-002 SHALL have parameter NCH, default 3, giving the channel count (TMR lanes).
REQ-003 SHALL have parameter DLY_W, default 16, giving the width of the delay and length fields.
REQ-004 SHALL have parameter SEED, default 16'hACE1, giving the LFSR reset value (nonzero).
REQ-005 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_in, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port data_in, input, NCH*WIDTH: channel c occupies bits [c*WIDTH +: WIDTH].
REQ-008 SHALL have port data_out, output, NCH*WIDTH: data_in XOR the fault mask.
REQ-009 SHALL have port cfg_valid, input, 1: the injection request.
REQ-010 SHALL have port cfg_ready, output, 1: high only in IDLE.
REQ-011 SHALL have port cfg_mode, input, 2: 0 none, 1 single, 2 burst, 3 random.
REQ-012 SHALL have port cfg_chan, input, clog2(NCH): the target channel.
REQ-013 SHALL have port cfg_bit, input, clog2(WIDTH): the target bit (single/burst modes).
REQ-014 SHALL have ports cfg_delay and cfg_len, input, DLY_W each: the wait cycles and the inject cycles.
REQ-015 SHALL have port abort, input, 1: cancels any pending or active injection.
REQ-016 SHALL have port cfg_err, output, 1: a one-cycle pulse on a rejected request.
REQ-017 SHALL have port inj_active, output, 1: high while the mask is nonzero.
REQ-018 SHALL have port inj_count, output, 16: the saturating count of injected cycles.

Function
REQ-019 SHALL accept a request when cfg_valid and cfg_ready are both high in the same cycle; cfg_valid while busy SHALL be ignored without side effect.
REQ-020 SHALL reject a request (cfg_err pulse next cycle, stay IDLE) if cfg_mode=0, cfg_chan>=NCH, or cfg_bit>=WIDTH in single/burst mode.
REQ-021 SHALL implement the FSM IDLE -> WAIT -> INJECT -> IDLE; on accept, go to WAIT when cfg_delay>0, otherwise straight to INJECT.
REQ-022 WAIT SHALL count down cfg_delay cycles, then enter INJECT.
REQ-023 INJECT SHALL last 1 cycle in single mode and max(cfg_len,1) cycles in burst/random mode, then return to IDLE.
REQ-024 SHALL register the mask; it is nonzero only during INJECT, with exactly one bit set, in the target channel.
REQ-025 SHALL compute data_out combinationally from data_in and the mask (zero added latency).
REQ-026 Single/burst mode SHALL flip cfg_bit (latched at accept) of cfg_chan.
REQ-027 Random mode SHALL advance the 16-bit LFSR (x^16+x^14+x^13+x^11+1) once per INJECT cycle and flip bit lfsr[clog2(WIDTH)-1:0], less WIDTH if that value is >=WIDTH.
REQ-028 SHALL increment inj_count once per INJECT cycle and hold it at 16'hFFFF (no wrap).
REQ-029 abort SHALL force IDLE and clear the mask on the next edge, with priority over every transition; abort in IDLE SHALL be a no-op.
REQ-030 SHALL latch all cfg fields at accept; later changes SHALL have no effect on the running injection.

Reset
REQ-031 While rst_in is low, SHALL hold state IDLE, mask 0, cfg_err 0, inj_count 0, LFSR=SEED, with cfg_ready=1 and data_out=data_in.
REQ-032 Reset asserted mid-WAIT or mid-INJECT SHALL clear the mask immediately, with no clock edge required.

Configuration
REQ-033 SHALL use macro FAULT_INJECT_EN; when defined, the full behaviour applies.
REQ-034 When FAULT_INJECT_EN is undefined, data_out SHALL equal data_in, cfg_ready/cfg_err/inj_active SHALL be 0, and inj_count SHALL be 0, with no state registers synthesised.

Structure
REQ-035 Package fi_pkg SHALL hold the mode encoding, the FSM state encoding, the LFSR taps and the default SEED.
REQ-036 The LFSR SHALL be sub-module fi_lfsr (ports clk, rst_in, en, q[15:0]).

Verification
REQ-037 Single: mode=1, chan=1, bit=5, delay=3, accepted at cycle 0 -> only data_out[37] is inverted, at cycle 4 only; inj_count=1.
REQ-038 Burst: mode=2, chan=2, bit=31, delay=0, len=4 -> bit 95 is inverted for 4 cycles starting the cycle after accept; cfg_ready is low throughout.
REQ-039 Reject: chan=3 with NCH=3 -> cfg_err pulses for 1 cycle; state stays IDLE; mask and inj_count unchanged.
REQ-040 Abort: burst with len=10, abort asserted at the 3rd INJECT cycle -> mask is 0 the next cycle; inj_count=3; cfg_ready=1.
REQ-041 Random: mode=3, len=8, SEED=16'hACE1 -> the 8 flipped bit indices match the reference-model LFSR sequence; one bit per cycle, all in the target channel.
REQ-042 Reset: rst_in low mid-burst -> data_out equals data_in in the same cycle; after release, inj_count=0 and cfg_ready=1.
